part2_mac_driver: RTL and testbench
===================================

# part2_mac_driver

Sequencer that sits in front of the MAC and drives its operand interface: `a`, `b`, `valid_in` and a clear. It also consumes the MAC's `f` / `valid_out` / `overflow` on the return side.

- Buffers one vector of DEPTH signed operand pairs from an upstream ready/valid stream.
- Clears the MAC, bursts the pairs into it on consecutive cycles, and counts returned `valid_out` pulses.
- Presents the final dot product and sticky overflow on a downstream ready/valid port.

## Interface
- DEPTH, 4: operand pairs per vector (2..16).
- clk  in  1: clock.
- reset  in  1: synchronous, active-high reset.
- s_valid  in  1: upstream pair valid.
- s_ready  out  1: driver can accept a pair.
- s_a  in  8: signed operand a.
- s_b  in  8: signed operand b.
- mac_a  out  8: to MAC `a`.
- mac_b  out  8: to MAC `b`.
- mac_valid  out  1: to MAC `valid_in`.
- mac_clear  out  1: one-cycle MAC clear; the integrator ORs it with `reset` onto the MAC's reset.
- mac_f  in  16: MAC accumulator `f`.
- mac_valid_out  in  1: MAC `valid_out`.
- mac_overflow  in  1: MAC sticky `overflow`.
- m_valid  out  1: result valid.
- m_ready  in  1: downstream accepts the result.
- m_f  out  16: signed dot product.
- m_overflow  out  1: overflow occurred during this vector.

## Operation
- FSM states: CLEAR, LOAD, STREAM, DRAIN, OUT. The reset state is CLEAR.
- CLEAR
  - Drives `mac_clear=1` for exactly one cycle.
  - Zeroes `wr_ptr`, `rd_ptr` and `vcnt`, then moves to LOAD.
- LOAD
  - Drives `s_ready=1`.
  - Each `s_valid&s_ready` writes `{s_a,s_b}` to `buf[wr_ptr]` and increments `wr_ptr`.
  - The handshake with `wr_ptr==DEPTH-1` moves to STREAM.
  - Bubbles on `s_valid` are allowed.
- STREAM
  - Drives `mac_valid=1`, `mac_a/mac_b = buf[rd_ptr]` and increments `rd_ptr` every cycle.
  - Runs for exactly DEPTH consecutive cycles with no gaps, then moves to DRAIN.
- Return counting
  - In STREAM and DRAIN, each `mac_valid_out` increments `vcnt`.
  - The pulse with `vcnt==DEPTH-1` captures `mac_f→m_f` and `mac_overflow→m_overflow`.
  - That capture moves the FSM to OUT from either state.
- OUT
  - Drives `m_valid=1`.
  - `m_f` and `m_overflow` are held stable until `m_ready`. The handshake moves to CLEAR.
- `mac_valid_out` pulses in CLEAR, LOAD or OUT are ignored.
- Outputs decode only from registers (state, pointers, buffer, capture registers). There is no combinational path from input to output.
- `mac_a` and `mac_b` are 0 whenever `mac_valid=0`.
- Arithmetic is done entirely in the MAC: signed 8×8 products, 16-bit wrapping sum. The driver never modifies `m_f`.
- `m_overflow` reflects the MAC's sticky flag. The MAC clear in CLEAR guarantees the flag and accumulator are per-vector.
- Reset at any point, including mid-STREAM and mid-OUT:
  - The FSM returns to CLEAR and pointers/counters are zeroed.
  - The buffered vector and any pending result are discarded.

## Timing
- Values after the first reset edge: `s_ready=0`, `mac_valid=0`, `mac_a=0`, `mac_b=0`, `m_valid=0`, `m_f=0`, `m_overflow=0`, `mac_clear=1` (state CLEAR).
- Let the first STREAM cycle be S:
  - `mac_valid` is high in cycles S..S+DEPTH-1.
  - The last `mac_valid_out` pulse arrives in cycle S+DEPTH+1. This is the MAC's 2-cycle latency.
  - `m_valid` rises in cycle S+DEPTH+2.
- STREAM starts the cycle after the final LOAD handshake.
- After the `m_ready` handshake: CLEAR for one cycle, then `s_ready=1` on the following cycle.
- `m_valid` with `m_ready` already high completes in one cycle.
- `s_ready` and `m_valid` are never high together.

## Structure
- Package `part2_pkg` holds:
  - DATA_W=8 and ACC_W=16.
  - The `drv_state_t` enum {CLEAR, LOAD, STREAM, DRAIN, OUT}.
  - The pair struct `{logic signed [7:0] a, b}`.
- Sub-module `part2_pair_buf` is a DEPTH-entry pair register file with one synchronous write port and one combinational read port. It has no reset; contents are don't-care until written.
- Pointers and `vcnt` are `$clog2(DEPTH)+1` bits wide.

## Test plan
- **Basic dot product.** DEPTH=4, pairs (1,2),(3,4),(5,6),(7,8) -> `m_f=100`, `m_overflow=0`. `m_valid` rises at S+6. `mac_valid` is high for exactly 4 contiguous cycles.
- **Overflow.** Pairs (127,127)×4 -> `m_overflow=1`, `m_f=-1020` (64516 wrapped).
- **Negative, no overflow.** Pairs (-128,127),(-128,127),(0,0),(-1,1) -> `m_f=-32513`, `m_overflow=0`.
- **Backpressure and back-to-back.** Hold `m_ready=0` for 10 cycles -> `m_f` and `m_valid` stable, `s_ready=0`, `mac_valid=0`. Next vector (2,3)×4 -> `m_f=24`, `m_overflow=0`, confirming the clear.
- **Load bubbles.** Random `s_valid` gaps during LOAD -> same result as the basic dot product; STREAM still 4 contiguous cycles.
- **Reset mid-operation.** Reset in the 2nd STREAM cycle -> no `m_valid`. `mac_clear` pulses once after reset, then `s_ready=1`. The following basic dot-product vector returns `m_f=100`.

Source files
------------

// File: rtl/part2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | part2_pkg                                                            |
// | Shared widths, driver state encoding and operand pair type.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package part2_pkg;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;

    typedef enum logic [2:0] {
        CLEAR  = 3'd0,
        LOAD   = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        OUT    = 3'd4
    } drv_state_t;

    typedef struct packed {
        logic signed [DATA_W-1:0] a;
        logic signed [DATA_W-1:0] b;
    } pair_t;

endpackage
`default_nettype wire

// File: rtl/part2_pair_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | part2_pair_buf                                                       |
// | DEPTH-entry operand pair store: sync write, combinational read.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module part2_pair_buf
    import part2_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  pair_t         wr_data,
    input  logic [AW-1:0] rd_addr,
    output pair_t         rd_data
);

    // No reset: entries are always written before they are read.
    pair_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/part2_mac_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | part2_mac_driver                                                     |
// | Buffers one operand vector, bursts it into the MAC, returns result.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module part2_mac_driver
    import part2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_a,
    input  logic [DATA_W-1:0] s_b,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    output logic              mac_valid,
    output logic              mac_clear,
    input  logic [ACC_W-1:0]  mac_f,
    input  logic              mac_valid_out,
    input  logic              mac_overflow,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ACC_W-1:0]  m_f,
    output logic              m_overflow
);

    localparam int c_ptr_w = $clog2(DEPTH) + 1;
    localparam int c_aw    = $clog2(DEPTH);
    localparam logic [c_ptr_w-1:0] c_last = c_ptr_w'(DEPTH - 1);
    localparam logic [c_ptr_w-1:0] c_one  = c_ptr_w'(1);

    drv_state_t           r_state;
    drv_state_t           w_next;
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w-1:0]   r_vcnt;
    logic [ACC_W-1:0]     r_m_f;
    logic                 r_m_ov;
    logic                 w_wr_en;
    logic                 w_counting;
    logic                 w_capture;
    pair_t                w_wr_pair;
    pair_t                w_rd_pair;

    assign w_wr_en    = (r_state == LOAD) && s_valid;
    assign w_counting = (r_state == STREAM) || (r_state == DRAIN);
    assign w_capture  = w_counting && mac_valid_out && (r_vcnt == c_last);
    assign w_wr_pair  = '{a: s_a, b: s_b};

    part2_pair_buf #(
        .DEPTH (DEPTH),
        .AW    (c_aw)
    ) u_pair_buf (
        .clk     (clk),
        .wr_en   (w_wr_en),
        .wr_addr (r_wr_ptr[c_aw-1:0]),
        .wr_data (w_wr_pair),
        .rd_addr (r_rd_ptr[c_aw-1:0]),
        .rd_data (w_rd_pair)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs decode from state and registered buffer contents only.
    always_comb begin
        w_next    = r_state;
        s_ready   = 1'b0;
        mac_valid = 1'b0;
        mac_clear = 1'b0;
        m_valid   = 1'b0;
        mac_a     = '0;
        mac_b     = '0;
        case (r_state)
            CLEAR: begin
                mac_clear = 1'b1;
                w_next    = LOAD;
            end
            LOAD: begin
                s_ready = 1'b1;
                if (s_valid && (r_wr_ptr == c_last)) begin
                    w_next = STREAM;
                end
            end
            STREAM: begin
                mac_valid = 1'b1;
                mac_a     = w_rd_pair.a;
                mac_b     = w_rd_pair.b;
                if (w_capture) begin
                    w_next = OUT;
                end else if (r_rd_ptr == c_last) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_capture) begin
                    w_next = OUT;
                end
            end
            OUT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    w_next = CLEAR;
                end
            end
            default: begin
                w_next = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_vcnt   <= '0;
            r_m_f    <= '0;
            r_m_ov   <= 1'b0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_vcnt   <= '0;
                end
                LOAD: begin
                    if (s_valid) begin
                        r_wr_ptr <= r_wr_ptr + c_one;
                    end
                end
                STREAM: begin
                    r_rd_ptr <= r_rd_ptr + c_one;
                end
                default: begin
                end
            endcase
            if (w_counting && mac_valid_out) begin
                r_vcnt <= r_vcnt + c_one;
            end
            if (w_capture) begin
                r_m_f  <= mac_f;
                r_m_ov <= mac_overflow;
            end
        end
    end

    assign m_f        = r_m_f;
    assign m_overflow = r_m_ov;

endmodule
`default_nettype wire

// File: tb/tb_part2_mac_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_part2_mac_driver                                                  |
// | Randomized bench with a MAC model and a cycle-level reference.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_part2_mac_driver;

    localparam int D   = 4;
    localparam int INF = 32'h7fff_ffff;

    logic        clk = 1'b0;
    logic        reset, s_valid, s_ready, mac_valid, mac_clear;
    logic        mac_valid_out, mac_overflow, m_valid, m_ready, m_overflow;
    logic [7:0]  s_a, s_b, mac_a, mac_b;
    logic [15:0] mac_f, m_f;

    always #5 clk = ~clk;

    part2_mac_driver #(.DEPTH(D)) dut (
        .clk           (clk),
        .reset         (reset),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_a           (s_a),
        .s_b           (s_b),
        .mac_a         (mac_a),
        .mac_b         (mac_b),
        .mac_valid     (mac_valid),
        .mac_clear     (mac_clear),
        .mac_f         (mac_f),
        .mac_valid_out (mac_valid_out),
        .mac_overflow  (mac_overflow),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_f           (m_f),
        .m_overflow    (m_overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // MAC stand-in: 2-cycle latency, wrapping 16-bit accumulate, sticky overflow.
    logic signed [15:0] mac_acc, mac_p;
    logic signed [16:0] mac_sum;
    logic               mac_ov, mac_v1, mac_v2, inject, inj;
    logic [15:0]        junk;

    assign mac_sum = 17'(mac_acc) + 17'(mac_p);

    always @(posedge clk) begin
        junk <= 16'($urandom);
        if (reset || mac_clear) begin
            mac_acc <= '0;
            mac_p   <= '0;
            mac_ov  <= 1'b0;
            mac_v1  <= 1'b0;
            mac_v2  <= 1'b0;
        end else begin
            mac_v1 <= mac_valid;
            mac_p  <= 16'($signed(mac_a)) * 16'($signed(mac_b));
            mac_v2 <= mac_v1;
            if (mac_v1) begin
                mac_acc <= mac_sum[15:0];
                if (mac_sum[16] != mac_sum[15]) mac_ov <= 1'b1;
            end
        end
    end

    // Spurious return pulses with garbage data while the driver must ignore them.
    assign inj           = inject && (s_ready || m_valid);
    assign mac_valid_out = mac_v2 || inj;
    assign mac_f         = inj ? junk : mac_acc;
    assign mac_overflow  = inj ? junk[0] : mac_ov;

    int ta[16], tbv[16];
    int pa[16], pb[16];

    function automatic int dot_ref(input int a[16], input int b[16], input int n, output bit ov);
        int acc;
        int t;
        acc = 0;
        ov  = 1'b0;
        for (int i = 0; i < n; i++) begin
            t = acc + a[i] * b[i];
            if (t > 32767 || t < -32768) ov = 1'b1;
            acc = shortint'(t);
        end
        return acc;
    endfunction

    // Reference timeline: expected outputs derived from handshake timestamps.
    int cyc = 0, clear_cyc = INF, hs_cyc = INF, nacc = 0, exp_f = 0;
    bit exp_ov = 1'b0, armed = 1'b0, post_rst = 1'b0;

    always @(negedge clk) begin
        bit e_clr, e_srdy, e_mv, e_out;
        int e_a, e_b;
        cyc++;
        e_clr  = (cyc == clear_cyc);
        e_srdy = (clear_cyc != INF) && (cyc > clear_cyc) && (cyc <= hs_cyc);
        e_mv   = (hs_cyc != INF) && (cyc > hs_cyc) && (cyc <= hs_cyc + D);
        e_out  = (hs_cyc != INF) && (cyc >= hs_cyc + D + 3);
        e_a    = e_mv ? pa[cyc - hs_cyc - 1] : 0;
        e_b    = e_mv ? pb[cyc - hs_cyc - 1] : 0;
        if (armed) begin
            chk("mac_clear", int'(mac_clear), int'(e_clr));
            chk("s_ready", int'(s_ready), int'(e_srdy));
            chk("mac_valid", int'(mac_valid), int'(e_mv));
            chk("mac_a", int'($signed(mac_a)), e_a);
            chk("mac_b", int'($signed(mac_b)), e_b);
            chk("m_valid", int'(m_valid), int'(e_out));
            if (e_out) begin
                chk("m_f", int'($signed(m_f)), exp_f);
                chk("m_overflow", int'(m_overflow), int'(exp_ov));
            end
            if (post_rst && e_clr) begin
                chk("reset_m_f", int'(m_f), 0);
                chk("reset_m_overflow", int'(m_overflow), 0);
            end
        end
        if (!reset && e_clr) post_rst = 1'b0;
        if (reset) begin
            armed     = 1'b1;
            post_rst  = 1'b1;
            clear_cyc = cyc + 1;
            hs_cyc    = INF;
            nacc      = 0;
        end else if (e_srdy && s_valid) begin
            pa[nacc] = int'($signed(s_a));
            pb[nacc] = int'($signed(s_b));
            nacc++;
            if (nacc == D) begin
                hs_cyc = cyc;
                exp_f  = dot_ref(pa, pb, D, exp_ov);
            end
        end else if (e_out && m_ready) begin
            clear_cyc = cyc + 1;
            hs_cyc    = INF;
            nacc      = 0;
        end
    end

    int tcyc = 0;
    always @(posedge clk) tcyc <= tcyc + 1;

    int last_f, last_hs, last_rise;
    bit last_ov;

    task automatic send_vec(input int bubble_pct);
        bit ok;
        for (int k = 0; k < D; k++) begin
            ok = 1'b0;
            while (int'($urandom_range(0, 99)) < bubble_pct) begin
                s_valid = 1'b0;
                s_a     = 8'($urandom);
                s_b     = 8'($urandom);
                @(posedge clk); #1;
            end
            s_valid = 1'b1;
            s_a     = 8'(ta[k]);
            s_b     = 8'(tbv[k]);
            for (int t = 0; t < 100 && !ok; t++) begin
                @(negedge clk);
                if (s_ready) begin
                    ok      = 1'b1;
                    last_hs = tcyc;
                end
                @(posedge clk); #1;
            end
            if (!ok) chk("load_timeout", 0, 1);
        end
        s_valid = 1'b0;
    endtask

    task automatic get_result(input bit early, input int hold);
        bit ok;
        ok      = 1'b0;
        m_ready = early;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (m_valid) begin
                ok        = 1'b1;
                last_rise = tcyc;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!ok) begin
            chk("result_timeout", 0, 1);
            m_ready = 1'b0;
            @(posedge clk); #1;
            return;
        end
        if (!early) begin
            for (int h = 0; h < hold; h++) @(posedge clk);
            @(posedge clk); #1 m_ready = 1'b1;
            @(negedge clk);
            chk("m_valid_held", int'(m_valid), 1);
        end
        last_f  = int'($signed(m_f));
        last_ov = m_overflow;
        @(posedge clk); #1 m_ready = 1'b0;
    endtask

    task automatic fill(input int a0, input int b0, input int a1, input int b1,
                        input int a2, input int b2, input int a3, input int b3);
        ta[0] = a0; tbv[0] = b0; ta[1] = a1; tbv[1] = b1;
        ta[2] = a2; tbv[2] = b2; ta[3] = a3; tbv[3] = b3;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  f, seen_mv, seen_clr;
        bit  ov;
        reset = 1'b1; s_valid = 1'b0; s_a = '0; s_b = '0; m_ready = 1'b0; inject = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        fill(1, 2, 3, 4, 5, 6, 7, 8);
        f = dot_ref(ta, tbv, D, ov);
        chk("ref_basic_f", f, 100);
        chk("ref_basic_ov", int'(ov), 0);
        fill(127, 127, 127, 127, 127, 127, 127, 127);
        f = dot_ref(ta, tbv, D, ov);
        chk("ref_ovf_f", f, -1020);
        chk("ref_ovf_ov", int'(ov), 1);

        fill(1, 2, 3, 4, 5, 6, 7, 8);
        send_vec(0);
        get_result(1'b1, 0);
        chk("basic_f", last_f, 100);
        chk("basic_ov", int'(last_ov), 0);
        chk("basic_latency", last_rise - last_hs, 7);

        fill(127, 127, 127, 127, 127, 127, 127, 127);
        send_vec(0);
        get_result(1'b0, 2);
        chk("ovf_f", last_f, -1020);
        chk("ovf_ov", int'(last_ov), 1);

        fill(-128, 127, -128, 127, 0, 0, -1, 1);
        send_vec(0);
        get_result(1'b0, 0);
        chk("neg_f", last_f, -32513);
        chk("neg_ov", int'(last_ov), 0);

        inject = 1'b1;
        fill(1, 2, 3, 4, 5, 6, 7, 8);
        send_vec(0);
        get_result(1'b0, 10);
        chk("bp_f", last_f, 100);
        fill(2, 3, 2, 3, 2, 3, 2, 3);
        send_vec(0);
        get_result(1'b1, 0);
        chk("b2b_f", last_f, 24);
        chk("b2b_ov", int'(last_ov), 0);
        inject = 1'b0;

        fill(1, 2, 3, 4, 5, 6, 7, 8);
        send_vec(60);
        get_result(1'b0, 1);
        chk("bubble_f", last_f, 100);

        fill(1, 2, 3, 4, 5, 6, 7, 8);
        send_vec(0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        seen_mv  = 0;
        seen_clr = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_valid) seen_mv++;
            if (mac_clear) seen_clr++;
        end
        chk("rst_no_m_valid", seen_mv, 0);
        chk("rst_clear_pulses", seen_clr, 1);
        @(posedge clk); #1;
        send_vec(0);
        get_result(1'b1, 0);
        chk("post_rst_f", last_f, 100);

        for (int v = 0; v < 20; v++) begin
            for (int k = 0; k < D; k++) begin
                ta[k]  = int'($urandom_range(0, 255)) - 128;
                tbv[k] = int'($urandom_range(0, 255)) - 128;
            end
            inject = 1'($urandom_range(0, 1));
            send_vec(int'($urandom_range(0, 50)));
            get_result(1'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
        end
        inject = 1'b0;

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
